// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program sequencer.
//   state_t    : sequencer FSM states
//   IDLE_WORD  : word driven onto the instruction bus whenever nothing is issuing
//   HOLD_CNT_W : width of the per-word hold counter (HOLD_CYCLES up to 15)
package prog_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  localparam logic [19:0] IDLE_WORD = 20'h00000;
  localparam int unsigned HOLD_CNT_W = 4;

endpackage

// File: rtl/prog_sequencer_if.sv
// Host-side bus of the program sequencer.
//   load_en/load_addr/load_data : program store write port
//   prog_len                    : words to issue, sampled on start
//   start                       : single-cycle run request
//   instruction/pc/busy/done    : issued word, its address and run status
// Optional macro PROG_SEQ_STEP_EN adds step_mode/step for single-stepping.
interface prog_sequencer_if #(
  parameter int unsigned INSTR_WIDTH = 20,
  parameter int unsigned ADDR_BITS   = 5
);

  logic                   load_en;
  logic [ADDR_BITS-1:0]   load_addr;
  logic [INSTR_WIDTH-1:0] load_data;
  logic [ADDR_BITS:0]     prog_len;
  logic                   start;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [ADDR_BITS-1:0]   pc;
  logic                   busy;
  logic                   done;
`ifdef PROG_SEQ_STEP_EN
  logic                   step_mode;
  logic                   step;
`endif

  modport master (
`ifdef PROG_SEQ_STEP_EN
    output step_mode, step,
`endif
    output load_en, load_addr, load_data, prog_len, start,
    input  instruction, pc, busy, done
  );

  modport slave (
`ifdef PROG_SEQ_STEP_EN
    input  step_mode, step,
`endif
    input  load_en, load_addr, load_data, prog_len, start,
    output instruction, pc, busy, done
  );

endinterface

// File: rtl/prog_sequencer_store.sv
// Program store: 2**ADDR_BITS x INSTR_WIDTH register array.
//   clk         : write clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata : asynchronous read port
// Contents are deliberately not reset.
module prog_store #(
  parameter int unsigned INSTR_WIDTH = 20,
  parameter int unsigned ADDR_BITS   = 5
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_BITS-1:0]   waddr,
  input  logic [INSTR_WIDTH-1:0] wdata,
  input  logic [ADDR_BITS-1:0]   raddr,
  output logic [INSTR_WIDTH-1:0] rdata
);

  logic [INSTR_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_sequencer.sv
// Instruction-issuing front end for simple_cpu. A host loads a program into
// the store, then pulses start; each word is presented on the instruction bus
// for HOLD_CYCLES rising edges, prog_len words in total, then done is raised.
//   clk : system clock (rising edge)
//   rst : synchronous, active-high reset
//   bus : prog_sequencer_if.slave (load port, start/prog_len, issued outputs)
// Optional macro PROG_SEQ_STEP_EN: with bus.step_mode high, an expired word is
// held until a cycle with bus.step high.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = 20,
  parameter int unsigned ADDR_BITS   = 5,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  prog_sequencer_if.slave bus
);

  localparam logic [HOLD_CNT_W-1:0]  HOLD_RELOAD = HOLD_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [INSTR_WIDTH-1:0] IDLE_INSTR  = INSTR_WIDTH'(IDLE_WORD);

  state_t                 state;
  logic [HOLD_CNT_W-1:0]  hold_cnt;
  logic [ADDR_BITS:0]     len;
  logic [ADDR_BITS-1:0]   pc;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   busy;
  logic                   done;

  logic [ADDR_BITS-1:0]   rd_addr;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic                   store_we;
  logic                   advance_ok;
  logic                   last_word;

  // One read port serves both cases: word 0 when a run is launched from
  // IDLE/DONE, and the next word while issuing.
  assign rd_addr   = (state == ISSUE) ? pc + 1'b1 : '0;
  assign store_we  = bus.load_en && (state != ISSUE);
  assign last_word = ({1'b0, pc} == len - 1'b1);

`ifdef PROG_SEQ_STEP_EN
  assign advance_ok = !bus.step_mode || bus.step;
`else
  assign advance_ok = 1'b1;
`endif

  prog_store #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .ADDR_BITS   (ADDR_BITS)
  ) u_store (
    .clk   (clk),
    .we    (store_we),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      len         <= '0;
      pc          <= '0;
      instruction <= IDLE_INSTR;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            if (bus.prog_len != '0) begin
              state       <= ISSUE;
              len         <= bus.prog_len;
              pc          <= '0;
              instruction <= rd_data;
              hold_cnt    <= HOLD_RELOAD;
              busy        <= 1'b1;
              done        <= 1'b0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else if (advance_ok) begin
            if (last_word) begin
              state       <= DONE;
              instruction <= IDLE_INSTR;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              pc          <= pc + 1'b1;
              instruction <= rd_data;
              hold_cnt    <= HOLD_RELOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.instruction = instruction;
  assign bus.pc          = pc;
  assign bus.busy        = busy;
  assign bus.done        = done;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed, scoreboard-based bench for prog_sequencer (HOLD_CYCLES = 4).
// Define PROG_SEQ_STEP_EN to also exercise single-step mode.
module tb_prog_sequencer;

  localparam int unsigned IW = 20;
  localparam int unsigned AB = 5;
  localparam int          H  = 4;

  typedef struct {
    string          tag;
    logic [IW-1:0]  instr;
    logic [AB-1:0]  pc;
    logic           busy;
    logic           done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  exp_t          sb[$];
  logic [IW-1:0] prog_words [32];
  int            errors = 0;
  int            checks = 0;

  prog_sequencer_if #(.INSTR_WIDTH(IW), .ADDR_BITS(AB)) bus ();

  prog_sequencer #(
    .INSTR_WIDTH (IW),
    .ADDR_BITS   (AB),
    .HOLD_CYCLES (H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Compare the DUT outputs against the oldest scoreboard entry.
  task automatic compare();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert ({bus.instruction, bus.pc, bus.busy, bus.done} === {e.instr, e.pc, e.busy, e.done})
    else begin
      errors++;
      $error("FAIL %s: observed instr=%h pc=%0d busy=%b done=%b, expected instr=%h pc=%0d busy=%b done=%b",
             e.tag, bus.instruction, bus.pc, bus.busy, bus.done, e.instr, e.pc, e.busy, e.done);
    end
  endtask

  // Push the expectation for the next edge, advance one cycle, compare.
  task automatic expect_cycle(input string tag, input logic [IW-1:0] instr,
                              input logic [AB-1:0] pc, input logic busy, input logic done);
    exp_t e;
    e.tag = tag; e.instr = instr; e.pc = pc; e.busy = busy; e.done = done;
    sb.push_back(e);
    @(posedge clk); #1;
    compare();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_word(input int addr, input logic [IW-1:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = AB'(addr);
    bus.load_data = data;
    prog_words[addr] = data;
    tick();
    bus.load_en = 1'b0;
  endtask

  // Issue a run of len words. inj_load_k / inj_start_k drive an illegal write
  // or a second start at run cycle k; rst_k asserts reset at run cycle k.
  task automatic run_prog(input string tag, input int len,
                          input int inj_load_k, input int inj_start_k, input int rst_k);
    bus.prog_len = (AB+1)'(len);
    for (int k = 0; k < len * H; k++) begin
      bus.start     = (k == 0) || (k == inj_start_k);
      bus.load_en   = (k == inj_load_k);
      bus.load_addr = 5'd1;
      bus.load_data = 20'hFFFFF;
      rst           = (k == rst_k);
      if (k == rst_k) begin
        expect_cycle({tag, "_rst"}, '0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        bus.start = 1'b0;
        bus.load_en = 1'b0;
        return;
      end
      expect_cycle(tag, prog_words[k / H], AB'(k / H), 1'b1, 1'b0);
    end
    bus.start   = 1'b0;
    bus.load_en = 1'b0;
    expect_cycle({tag, "_done"}, '0, AB'(len - 1), 1'b0, 1'b1);
    expect_cycle({tag, "_done_hold"}, '0, AB'(len - 1), 1'b0, 1'b1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.prog_len  = '0;
    bus.start     = 1'b0;
`ifdef PROG_SEQ_STEP_EN
    bus.step_mode = 1'b0;
    bus.step      = 1'b0;
`endif

    // Reset then idle.
    expect_cycle("reset0", '0, '0, 1'b0, 1'b0);
    expect_cycle("reset1", '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) expect_cycle("idle", '0, '0, 1'b0, 1'b0);

    // Zero-length program: straight to DONE, busy never rises.
    bus.prog_len = '0;
    bus.start    = 1'b1;
    expect_cycle("len0_start", '0, '0, 1'b0, 1'b1);
    bus.start = 1'b0;
    expect_cycle("len0_hold", '0, '0, 1'b0, 1'b1);

    // Full-length program: pc 0..31 without wrap, 128 busy cycles.
    for (int a = 0; a < 32; a++) load_word(a, IW'(32'h10000 + a * 32'h111));
    run_prog("len32", 32, -1, -1, -1);

    // Basic three-word program.
    load_word(0, 20'h47000);
    load_word(1, 20'h53000);
    load_word(2, 20'h72001);
    run_prog("basic", 3, -1, -1, -1);

    // Store write and second start during a run are both ignored.
    run_prog("ignored", 3, 3, 5, -1);

    // Reset mid-run, then rerun the retained program.
    run_prog("midrst", 3, -1, -1, 6);
    expect_cycle("after_rst", '0, '0, 1'b0, 1'b0);
    run_prog("rerun", 3, -1, -1, -1);

`ifdef PROG_SEQ_STEP_EN
    // Step mode: word 0 held until the step pulse at cycle 10; a step while
    // the counter is still running (cycle 2) has no effect.
    bus.step_mode = 1'b1;
    bus.prog_len  = 6'd3;
    for (int k = 0; k < 18; k++) begin
      bus.start = (k == 0);
      bus.step  = (k == 2) || (k == 10);
      if (k == 11) bus.step_mode = 1'b0;
      if (k < 10)      expect_cycle("step_hold", 20'h47000, 5'd0, 1'b1, 1'b0);
      else if (k < 14) expect_cycle("step_w1",   20'h53000, 5'd1, 1'b1, 1'b0);
      else             expect_cycle("step_w2",   20'h72001, 5'd2, 1'b1, 1'b0);
    end
    bus.step = 1'b0;
    expect_cycle("step_done", '0, 5'd2, 1'b0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Instruction-issuing front end for simple_cpu. It drives the 20-bit `instruction` bus that the CPU consumes.
- Holds a small program store that a host writes through a load port. On `start`, it plays the program out one word at a time.
- Each word is held stable for a fixed number of clock cycles, which is the CPU's per-instruction execution window.
- It replaces hand-driven instruction stimulus at the CPU input and sits between the host/bench and simple_cpu.

Parameters:
- INSTR_WIDTH, 20, instruction word width; must match simple_cpu.
- ADDR_BITS, 5, program store address width; depth = 2**ADDR_BITS = 32 words.
- HOLD_CYCLES, 4, rising edges each word is presented to the CPU; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_en  in  1  write strobe for the program store.
- load_addr  in  ADDR_BITS  program store write address.
- load_data  in  INSTR_WIDTH  program word to write.
- prog_len  in  ADDR_BITS+1  number of words to issue (0..32); sampled on start.
- start  in  1  single-cycle request to run the program from address 0.
- instruction  out  INSTR_WIDTH  word presented to simple_cpu (registered).
- pc  out  ADDR_BITS  address of the word currently presented.
- busy  out  1  high while issuing.
- done  out  1  high after the last word completes; cleared by start or rst.

Behaviour:
- Reset values: instruction = 0 (IDLE_WORD), pc = 0, busy = 0, done = 0, state = IDLE, hold counter = 0, latched length = 0. Program store contents are NOT reset.
- Program store: synchronous write when load_en is high and state is IDLE or DONE; asynchronous read. load_en while busy is ignored and the store is unchanged.
- FSM states: IDLE, ISSUE, DONE.
- IDLE/DONE --start and prog_len != 0--> ISSUE:
  - latch prog_len, pc <= 0, instruction <= mem[0];
  - hold counter <= HOLD_CYCLES-1; busy <= 1; done <= 0.
- IDLE/DONE --start and prog_len == 0--> DONE: done <= 1, busy stays 0, instruction stays IDLE_WORD.
- ISSUE, counter != 0: decrement counter; instruction and pc held stable.
- ISSUE, counter == 0 and pc != len-1: pc <= pc+1, instruction <= mem[pc+1], counter <= HOLD_CYCLES-1.
- ISSUE, counter == 0 and pc == len-1: go to DONE, instruction <= IDLE_WORD, busy <= 0, done <= 1, pc holds the last address.
- Timing: start sampled at edge N, so word 0 is visible after edge N. Each word is visible for exactly HOLD_CYCLES cycles. busy is high for exactly prog_len*HOLD_CYCLES cycles.
- prog_len = 32: pc reaches 31 with no wrap, then goes to DONE.
- start while in ISSUE is ignored; there is no restart mid-run.
- Simultaneous load_en and start in IDLE: the write completes first. Word 0 read that edge returns the OLD content if load_addr == 0; hosts must load before start.
- rst mid-run: next edge returns to the reset state and instruction = 0 immediately; the store is kept, so a subsequent start reruns the same program.

Optional Feature:
- Macro: PROG_SEQ_STEP_EN.
- Defined: adds input ports `step_mode` and `step` (1 bit each).
  - With step_mode high, when the counter expires the FSM does not advance. It holds the current word until a cycle with step high, then advances on that edge.
  - step high while the counter != 0 is ignored.
  - step_mode low gives the normal behaviour.
- Undefined: no extra ports; free-running behaviour only.

Decomposition:
- Package prog_seq_pkg:
  - state enum {IDLE, ISSUE, DONE};
  - IDLE_WORD = 20'h00000;
  - HOLD_CNT_W = 4.
- One sub-module, prog_store: 2**ADDR_BITS x INSTR_WIDTH register array with synchronous write and asynchronous read.
- The FSM, counter and output registers stay in prog_sequencer.

Test Plan:
- Reset then idle: rst high 2 cycles, then idle 5 cycles -> instruction = 0, pc = 0, busy = 0, done = 0 throughout.
- Basic run, HOLD_CYCLES = 4:
  - stimulus: load 0x47000@0, 0x53000@1, 0x72001@2, prog_len = 3, pulse start;
  - response: instruction = 0x47000 for 4 cycles, then 0x53000 for 4, then 0x72001 for 4, then 0;
  - busy high for 12 cycles, then done = 1 and pc = 2.
- Zero/full length:
  - prog_len = 0 with start -> done = 1 next edge, busy never asserts;
  - prog_len = 32 -> pc counts 0..31, busy for 128 cycles, no wrap.
- Ignored events during run:
  - load_en with addr 1, data 0xFFFFF at cycle 3 of the run, plus a start pulse at cycle 5;
  - response: word 1 still issues 0x53000, run length unchanged (12 cycles).
- Reset mid-run:
  - rst at cycle 6 of the 3-word run -> instruction = 0, busy = 0 next edge;
  - new start reissues 0x47000 first.
- PROG_SEQ_STEP_EN, step_mode = 1: word 0 is held 10 cycles until a step pulse, then 0x53000 appears on the following edge.
